// File: rtl/multdiv_seq_ctrl_pkg.sv
// multdiv_seq_ctrl_pkg: state encoding, Booth window codes and counter-width helper
// for the multiply/divide sequencer.
package multdiv_seq_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, MULT, DIV, DIV_FIX, NEG, DONE} state_t;
    localparam logic [2:0] BOOTH_ZERO_LO = 3'b000;
    localparam logic [2:0] BOOTH_ZERO_HI = 3'b111;
    localparam logic [2:0] BOOTH_P2M     = 3'b011;
    localparam logic [2:0] BOOTH_M2M     = 3'b100;
    function automatic int cw_of(input int width);
        return $clog2(width) + 1;
    endfunction
endpackage

// File: rtl/multdiv_seq_ctrl_booth.sv
// multdiv_seq_ctrl_booth: radix-4 Booth decode of the {Q[1],Q[0],Q[-1]} window.
//   llsb_Q     in  3  Booth window
//   A_add_zero out 1  add nothing this step
//   M_negate   out 1  subtract the (possibly doubled) multiplicand
//   M_sl1      out 1  use 2M
module multdiv_seq_ctrl_booth
    import multdiv_seq_ctrl_pkg::*;
(
    input  logic [2:0] llsb_Q,
    output logic       A_add_zero,
    output logic       M_negate,
    output logic       M_sl1
);
    always_comb begin
        A_add_zero = (llsb_Q == BOOTH_ZERO_LO) || (llsb_Q == BOOTH_ZERO_HI);
        // 100/101/110 subtract; 111 is a zero step, not a negative one
        M_negate   = llsb_Q[2] && (llsb_Q != BOOTH_ZERO_HI);
        M_sl1      = (llsb_Q == BOOTH_P2M) || (llsb_Q == BOOTH_M2M);
    end
endmodule

// File: rtl/multdiv_seq_ctrl.sv
// multdiv_seq_ctrl: FSM sequencer issuing per-cycle strobes to the A/Q/M multdiv datapath.
//   clock, reset (async, active-high)   start/should_div/divisor_is_zero/sign_flip: op request
//   llsb_Q, mmsb_A: datapath feedback   A_add_zero..result_negate: datapath strobes
//   busy: op in flight   ready: 1-cycle result pulse   exception: div-by-zero with ready
//   count: iteration counter
module multdiv_seq_ctrl
    import multdiv_seq_ctrl_pkg::*;
#(
    parameter  int WIDTH      = 32,
    parameter  bit SIGNED_DIV = 1'b1,
    localparam int CW         = cw_of(WIDTH)
)
(
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          should_div,
    input  logic          divisor_is_zero,
    input  logic          sign_flip,
    input  logic [2:0]    llsb_Q,
    input  logic          mmsb_A,
    output logic          A_add_zero,
    output logic          M_negate,
    output logic          M_sl1,
    output logic          AQ_we,
    output logic          AQ_sra2,
    output logic          AQ_sl1,
    output logic          A_correct,
    output logic          result_negate,
    output logic          busy,
    output logic          ready,
    output logic          exception,
    output logic [CW-1:0] count
);
    localparam logic [CW-1:0] MULT_LAST = CW'(WIDTH / 2 - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(WIDTH - 1);

    state_t state, next_state;
    logic   exc_q, sign_flip_q;
    logic   b_zero, b_neg, b_sl1;

    multdiv_seq_ctrl_booth u_booth (
        .llsb_Q     (llsb_Q),
        .A_add_zero (b_zero),
        .M_negate   (b_neg),
        .M_sl1      (b_sl1)
    );

    always_comb begin
        next_state    = state;
        A_add_zero    = 1'b0;
        M_negate      = 1'b0;
        M_sl1         = 1'b0;
        AQ_we         = 1'b0;
        AQ_sra2       = 1'b0;
        AQ_sl1        = 1'b0;
        A_correct     = 1'b0;
        result_negate = 1'b0;
        ready         = 1'b0;
        exception     = 1'b0;
        busy          = state != IDLE;
        case (state)
            MULT: begin
                A_add_zero = b_zero;
                M_negate   = b_neg;
                M_sl1      = b_sl1;
                AQ_we      = 1'b1;
                AQ_sra2    = 1'b1;
                next_state = (count == MULT_LAST) ? DONE : MULT;
            end
            DIV: begin
                AQ_sl1     = 1'b1;
                AQ_we      = 1'b1;
                // first non-restoring step always subtracts
                M_negate   = (count == '0) || !mmsb_A;
                next_state = (count == DIV_LAST) ? DIV_FIX : DIV;
            end
            DIV_FIX: begin
                A_correct  = mmsb_A;
                AQ_we      = mmsb_A;
                next_state = (SIGNED_DIV && sign_flip_q) ? NEG : DONE;
            end
            NEG: begin
                result_negate = 1'b1;
                AQ_we         = 1'b1;
                next_state    = DONE;
            end
            DONE: begin
                ready      = 1'b1;
                exception  = exc_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // a start from any state aborts whatever is in flight
        if (start) next_state = !should_div ? MULT : divisor_is_zero ? DONE : DIV;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            exc_q       <= 1'b0;
            sign_flip_q <= 1'b0;
        end else begin
            state <= next_state;
            if (start) begin
                count       <= '0;
                exc_q       <= should_div && divisor_is_zero;
                sign_flip_q <= sign_flip;
            end else if (state == MULT || state == DIV) begin
                count <= count + 1'b1;
            end
        end
    end
endmodule
